branch_redirect_ctrl: RTL and testbench

- Sequences front-end recovery after a branch mispredict or an exception redirect.
- Takes the mispredict strobe and its correct target from the branch execution unit, plus a trap-vector redirect from the exception path.
- Flushes decode/issue, stalls issue, and hands the redirect address to fetch over a valid/ready handshake.
- Holds issue stalled until fetch delivers the first instruction at the target. Re-issues the redirect if refill times out.

---
 rtl/branch_redirect_ctrl.sv | 122 ++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Front-end recovery sequencer for branch mispredicts and exception redirects.
// On an accepted event it flushes decode/issue for one cycle, offers the
// redirect target to fetch over a valid/ready handshake, then holds issue
// stalled until fetch returns the first instruction at that target. If that
// instruction does not arrive within REFILL_TIMEOUT cycles, the redirect is
// offered again.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mispredict_valid_i/target_i mispredict strobe and correct target
//   exception_valid_i/vector_i  exception redirect strobe and trap vector
//   flush_o                     one-cycle kill of younger decode/issue state
//   stall_issue_o               issue blocked while recovery is in progress
//   fetch_redirect_valid_o/addr_o/ready_i  redirect handshake to fetch
//   fetch_instr_valid_i/addr_i  instruction presented by fetch to decode
//   timeout_error_o             one-cycle pulse when a refill timeout re-issues
//   redirect_count_o            completed recoveries, saturating
module branch_redirect_ctrl #(
  parameter int unsigned ALEN           = 32,
  parameter int unsigned REFILL_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mispredict_valid_i,
  input  logic [ALEN-1:0] mispredict_target_i,
  input  logic            exception_valid_i,
  input  logic [ALEN-1:0] exception_vector_i,
  output logic            flush_o,
  output logic            stall_issue_o,
  output logic            fetch_redirect_valid_o,
  output logic [ALEN-1:0] fetch_redirect_addr_o,
  input  logic            fetch_redirect_ready_i,
  input  logic            fetch_instr_valid_i,
  input  logic [ALEN-1:0] fetch_instr_addr_i,
  output logic            timeout_error_o,
  output logic [15:0]     redirect_count_o
);

  typedef enum logic [1:0] {StIdle, StFlush, StRedirect, StRefill} state_e;

  state_e          state_q, state_d;
  logic [ALEN-1:0] target_q, target_d;
  logic [7:0]      tmo_cnt_q, tmo_cnt_d;
  logic            timeout_q, timeout_d;
  logic [15:0]     redirect_count_q, redirect_count_d;
  logic [7:0]      tmo_cnt_inc;

  assign tmo_cnt_inc = tmo_cnt_q + 8'd1;

  always_comb begin
    state_d          = state_q;
    target_d         = target_q;
    tmo_cnt_d        = tmo_cnt_q;
    timeout_d        = 1'b0;
    redirect_count_d = redirect_count_q;

    unique case (state_q)
      StIdle: begin
        if (exception_valid_i) begin
          target_d = exception_vector_i;
          state_d  = StFlush;
        end else if (mispredict_valid_i) begin
          target_d = mispredict_target_i;
          state_d  = StFlush;
        end
      end
      StFlush: state_d = StRedirect;
      StRedirect: begin
        if (fetch_redirect_ready_i) begin
          state_d   = StRefill;
          tmo_cnt_d = 8'd0;
        end
      end
      StRefill: begin
        tmo_cnt_d = tmo_cnt_inc;
        if (fetch_instr_valid_i && (fetch_instr_addr_i == target_q)) begin
          state_d          = StIdle;
          redirect_count_d = (redirect_count_q == 16'hFFFF) ? redirect_count_q
                                                            : redirect_count_q + 16'd1;
        end else if (tmo_cnt_inc == 8'(REFILL_TIMEOUT)) begin
          state_d   = StRedirect;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // An exception mid-recovery overrides everything decided above, including
    // a same-cycle handshake, refill match or timeout.
    if ((state_q != StIdle) && exception_valid_i) begin
      state_d          = StFlush;
      target_d         = exception_vector_i;
      timeout_d        = 1'b0;
      redirect_count_d = redirect_count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      target_q         <= '0;
      tmo_cnt_q        <= 8'd0;
      timeout_q        <= 1'b0;
      redirect_count_q <= 16'd0;
    end else begin
      state_q          <= state_d;
      target_q         <= target_d;
      tmo_cnt_q        <= tmo_cnt_d;
      timeout_q        <= timeout_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  // All outputs decode straight from registers.
  assign flush_o                = (state_q == StFlush);
  assign stall_issue_o          = (state_q != StIdle);
  assign fetch_redirect_valid_o = (state_q == StRedirect);
  assign fetch_redirect_addr_o  = target_q;
  assign timeout_error_o        = timeout_q;
  assign redirect_count_o       = redirect_count_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl. The stimulus pushes each expected
// redirect address into a queue; a monitor pops and compares it on every
// accepted fetch handshake. Flush, stall, timeout and count are checked
// directly against hand-computed values.
module tb_branch_redirect_ctrl;

  localparam int unsigned ALEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mispredict_valid = 1'b0;
  logic [ALEN-1:0] mispredict_target = '0;
  logic            exception_valid = 1'b0;
  logic [ALEN-1:0] exception_vector = '0;
  logic            flush, stall_issue, fetch_redirect_valid, timeout_error;
  logic [ALEN-1:0] fetch_redirect_addr;
  logic            fetch_redirect_ready = 1'b1;
  logic            fetch_instr_valid = 1'b0;
  logic [ALEN-1:0] fetch_instr_addr = '0;
  logic [15:0]     redirect_count;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  logic [ALEN-1:0] sb_q[$];

  branch_redirect_ctrl #(.ALEN(ALEN), .REFILL_TIMEOUT(4)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .mispredict_valid_i     (mispredict_valid),
    .mispredict_target_i    (mispredict_target),
    .exception_valid_i      (exception_valid),
    .exception_vector_i     (exception_vector),
    .flush_o                (flush),
    .stall_issue_o          (stall_issue),
    .fetch_redirect_valid_o (fetch_redirect_valid),
    .fetch_redirect_addr_o  (fetch_redirect_addr),
    .fetch_redirect_ready_i (fetch_redirect_ready),
    .fetch_instr_valid_i    (fetch_instr_valid),
    .fetch_instr_addr_i     (fetch_instr_addr),
    .timeout_error_o        (timeout_error),
    .redirect_count_o       (redirect_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Quick recovery with ready high and an immediate matching instruction.
  task automatic run_recovery(input logic [ALEN-1:0] addr);
    mispredict_valid = 1'b1;
    mispredict_target = addr;
    sb_q.push_back(addr);
    tick();
    mispredict_valid = 1'b0;
    tick();
    tick();
    fetch_instr_valid = 1'b1;
    fetch_instr_addr = addr;
    tick();
    fetch_instr_valid = 1'b0;
  endtask

  // Scoreboard monitor: every accepted redirect must match the next expected.
  always @(negedge clk) begin
    if (rst_n && fetch_redirect_valid && fetch_redirect_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_redirect", fetch_redirect_addr, 32'hFFFF_FFFF);
      end else begin
        chk("sb_redirect_addr", fetch_redirect_addr, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #3;
    chk("rst_flush", flush, 0);
    chk("rst_stall", stall_issue, 0);
    chk("rst_valid", fetch_redirect_valid, 0);
    chk("rst_addr", fetch_redirect_addr, 0);
    chk("rst_count", redirect_count, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: basic mispredict, ready tied high
    mispredict_valid = 1'b1;
    mispredict_target = 32'h0000_1000;
    sb_q.push_back(32'h0000_1000);
    tick();
    mispredict_valid = 1'b0;
    chk("t1_flush", flush, 1);
    chk("t1_stall", stall_issue, 1);
    chk("t1_valid_early", fetch_redirect_valid, 0);
    tick();
    chk("t1_flush_once", flush, 0);
    chk("t1_valid", fetch_redirect_valid, 1);
    chk("t1_addr", fetch_redirect_addr, 32'h0000_1000);
    tick();
    chk("t1_refill_valid", fetch_redirect_valid, 0);
    chk("t1_refill_stall", stall_issue, 1);
    fetch_instr_valid = 1'b1;
    fetch_instr_addr = 32'h0000_1000;
    tick();
    fetch_instr_valid = 1'b0;
    chk("t1_stall_drop", stall_issue, 0);
    chk("t1_count", redirect_count, 1);

    // 2: simultaneous mispredict and exception, exception wins
    mispredict_valid = 1'b1;
    mispredict_target = 32'h0000_2000;
    exception_valid = 1'b1;
    exception_vector = 32'h0000_8000;
    sb_q.push_back(32'h0000_8000);
    tick();
    mispredict_valid = 1'b0;
    exception_valid = 1'b0;
    chk("t2_flush", flush, 1);
    tick();
    chk("t2_flush_once", flush, 0);
    chk("t2_addr", fetch_redirect_addr, 32'h0000_8000);
    tick();
    fetch_instr_valid = 1'b1;
    fetch_instr_addr = 32'h0000_8000;
    tick();
    fetch_instr_valid = 1'b0;
    chk("t2_count", redirect_count, 2);

    // 3: backpressure, then mispredict ignored in REFILL
    fetch_redirect_ready = 1'b0;
    mispredict_valid = 1'b1;
    mispredict_target = 32'h0000_3000;
    sb_q.push_back(32'h0000_3000);
    tick();
    mispredict_target = 32'h0000_5000;  // wrong-path strobe, must be ignored
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("t3_bp_valid", fetch_redirect_valid, 1);
      chk("t3_bp_addr", fetch_redirect_addr, 32'h0000_3000);
      if (i < 5) tick();
    end
    mispredict_valid = 1'b0;
    fetch_redirect_ready = 1'b1;
    tick();
    chk("t3_refill_valid", fetch_redirect_valid, 0);
    mispredict_valid = 1'b1;
    mispredict_target = 32'h0000_6000;
    tick();
    mispredict_valid = 1'b0;
    chk("t3_ignore_flush", flush, 0);
    chk("t3_ignore_stall", stall_issue, 1);
    chk("t3_ignore_addr", fetch_redirect_addr, 32'h0000_3000);
    fetch_instr_valid = 1'b1;
    fetch_instr_addr = 32'h0000_3000;
    tick();
    fetch_instr_valid = 1'b0;
    chk("t3_count", redirect_count, 3);

    // 4: refill timeout with a wrong-path instruction present
    mispredict_valid = 1'b1;
    mispredict_target = 32'h0000_1000;
    sb_q.push_back(32'h0000_1000);
    sb_q.push_back(32'h0000_1000);
    tick();
    mispredict_valid = 1'b0;
    tick();
    tick();  // now in REFILL, counter cleared
    fetch_instr_valid = 1'b1;
    fetch_instr_addr = 32'h0000_1004;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_timeout", timeout_error, 0);
      chk("t4_refill_valid", fetch_redirect_valid, 0);
    end
    tick();
    chk("t4_timeout", timeout_error, 1);
    chk("t4_reissue_valid", fetch_redirect_valid, 1);
    chk("t4_reissue_addr", fetch_redirect_addr, 32'h0000_1000);
    chk("t4_count_hold", redirect_count, 3);
    tick();
    chk("t4_timeout_once", timeout_error, 0);
    fetch_instr_addr = 32'h0000_1000;
    tick();
    fetch_instr_valid = 1'b0;
    chk("t4_count", redirect_count, 4);

    // 5: exception preempts REFILL; then preempts a same-cycle refill match
    mispredict_valid = 1'b1;
    mispredict_target = 32'h0000_1000;
    sb_q.push_back(32'h0000_1000);
    tick();
    mispredict_valid = 1'b0;
    tick();
    tick();
    exception_valid = 1'b1;
    exception_vector = 32'h0000_8000;
    sb_q.push_back(32'h0000_8000);
    tick();
    exception_valid = 1'b0;
    chk("t5_flush2", flush, 1);
    tick();
    chk("t5_addr", fetch_redirect_addr, 32'h0000_8000);
    tick();
    fetch_instr_valid = 1'b1;
    fetch_instr_addr = 32'h0000_8000;
    exception_valid = 1'b1;
    exception_vector = 32'h0000_9000;
    sb_q.push_back(32'h0000_9000);
    tick();
    exception_valid = 1'b0;
    fetch_instr_valid = 1'b0;
    chk("t5_match_preempt_flush", flush, 1);
    chk("t5_match_preempt_count", redirect_count, 4);
    tick();
    chk("t5_addr_9000", fetch_redirect_addr, 32'h0000_9000);
    tick();
    fetch_instr_valid = 1'b1;
    fetch_instr_addr = 32'h0000_9000;
    tick();
    fetch_instr_valid = 1'b0;
    chk("t5_count", redirect_count, 5);

    // 6: asynchronous reset mid-REDIRECT
    fetch_redirect_ready = 1'b0;
    mispredict_valid = 1'b1;
    mispredict_target = 32'h0000_4000;
    tick();
    mispredict_valid = 1'b0;
    tick();
    chk("t6_in_redirect", fetch_redirect_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", fetch_redirect_valid, 0);
    chk("t6_rst_stall", stall_issue, 0);
    chk("t6_rst_flush", flush, 0);
    chk("t6_rst_count", redirect_count, 0);
    tick();
    rst_n = 1'b1;
    fetch_redirect_ready = 1'b1;
    tick();
    chk("t6_idle_stall", stall_issue, 0);
    chk("t6_idle_flush", flush, 0);

    // 7: saturation via backdoor preload
    force dut.redirect_count_q = 16'hFFFE;
    tick();
    release dut.redirect_count_q;
    tick();
    chk("t7_preload", redirect_count, 16'hFFFE);
    run_recovery(32'h0000_A000);
    chk("t7_count_max", redirect_count, 16'hFFFF);
    run_recovery(32'h0000_B000);
    chk("t7_count_sat", redirect_count, 16'hFFFF);

    tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
